// File: rtl/ab_stim_sequencer_if.sv
// Signal bundle between a stimulus sequencer, its controller and the FSM it exercises.
// The slave side is the sequencer; the master side is whoever programs it and hosts the FSM.
interface ab_stim_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             wr_en;
    logic [3:0]       wr_addr;
    logic [2:0]       wr_data;
    logic [4:0]       len;
    logic             start;
    logic             abort;
    logic             dut_rst;
    logic             dut_a;
    logic             dut_b;
    logic             dut_y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output wr_en, wr_addr, wr_data, len, start, abort, dut_y,
        input  dut_rst, dut_a, dut_b, busy, done, pass, err_cnt
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, len, start, abort, dut_y,
        output dut_rst, dut_a, dut_b, busy, done, pass, err_cnt
    );
endinterface

// File: rtl/ab_stim_sequencer.sv
// Steps a two-input FSM through a stored (a,b) program and checks its registered
// output y one cycle later against the stored expected value of each step.
module ab_stim_sequencer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    ab_stim_sequencer_if.slave bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {IDLE, DRST, DRIVE, FLUSH, DONE} state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    last_idx;
    logic [IW-1:0]    wr_idx;
    logic [2:0]       store [DEPTH];
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] err_next;
    logic             pass;
    logic             busy;
    logic             len_ok;
    logic             wr_ok;
    logic             check_en;
    logic             check_exp;
    logic             mismatch;
    logic             unused_addr;

    // Upper address bits alias onto the low ones, so they are deliberately ignored.
    assign wr_idx      = bus.wr_addr[IW-1:0];
    assign unused_addr = ^bus.wr_addr;
    assign busy        = (state == DRST) || (state == DRIVE) || (state == FLUSH);
    assign wr_ok       = bus.wr_en && !busy && (int'(wr_idx) < DEPTH);
    assign len_ok      = (bus.len != 5'd0) && (int'(bus.len) <= DEPTH);

    // y seen now was registered on the edge that closed the previous step.
    always_comb begin
        check_en  = 1'b0;
        check_exp = 1'b0;
        if (state == DRIVE && idx != '0) begin
            check_en  = 1'b1;
            check_exp = store[idx - IW'(1)][0];
        end else if (state == FLUSH) begin
            check_en  = 1'b1;
            check_exp = store[last_idx][0];
        end
    end

    assign mismatch = check_en && (bus.dut_y != check_exp);
    assign err_next = (mismatch && (err_cnt != '1)) ? err_cnt + CNT_W'(1) : err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            last_idx <= '0;
            err_cnt  <= '0;
            pass     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else begin
            if (wr_ok) begin
                store[wr_idx] <= bus.wr_data;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        pass <= 1'b0;
                        if (len_ok) begin
                            last_idx <= IW'(bus.len - 5'd1);
                            idx      <= '0;
                            err_cnt  <= '0;
                            state    <= DRST;
                        end else begin
                            err_cnt <= '1;
                            state   <= DONE;
                        end
                    end
                end
                DRST: begin
                    if (bus.abort) begin
                        pass  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (bus.abort) begin
                        pass  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        err_cnt <= err_next;
                        if (idx == last_idx) begin
                            state <= FLUSH;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (bus.abort) begin
                        pass  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        err_cnt <= err_next;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    pass  <= (err_cnt == '0);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FSM-facing outputs are decoded straight from state so step i lands in DRIVE cycle i.
    assign bus.dut_rst = (state == DRST);
    assign bus.dut_a   = (state == DRIVE) && store[idx][2];
    assign bus.dut_b   = (state == DRIVE) && store[idx][1];
    assign bus.busy    = busy;
    assign bus.done    = (state == DONE);
    assign bus.pass    = pass;
    assign bus.err_cnt = err_cnt;
endmodule
